// File: rtl/mem_access_seq.sv
// mem_access_seq: multicycle sequencer for fetch, load and store accesses.
// It checks alignment, runs the MMU translation handshake, then runs the
// external bus cycle with a timeout.
// Ports:
//   Clk, Reset (async, active-low)
//   Start_I, Fetch_I, Wr_I, Size_I, Addr_Low2_I  access request from controller
//   Abort_I                                      cancel of in-flight access
//   Pr_Req_O, MMU_Ack_I, TLB_Err_I, TLB_Fault_I  MMU translation handshake
//   Bus_Req_O, Bus_Wr_O, Bus_Rdy_I               external bus cycle
//   IR_Load_O, Busy_O, Done_O, Exc_O, ExcCode_O  status back to controller
module mem_access_seq #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start_I,
    input  logic       Fetch_I,
    input  logic       Wr_I,
    input  logic [1:0] Size_I,
    input  logic [1:0] Addr_Low2_I,
    input  logic       Abort_I,
    output logic       Pr_Req_O,
    input  logic       MMU_Ack_I,
    input  logic       TLB_Err_I,
    input  logic [2:0] TLB_Fault_I,
    output logic       Bus_Req_O,
    output logic       Bus_Wr_O,
    input  logic       Bus_Rdy_I,
    output logic       IR_Load_O,
    output logic       Busy_O,
    output logic       Done_O,
    output logic       Exc_O,
    output logic [4:0] ExcCode_O
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_XLATE,
        S_BUS,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_q, fetch_d;
    logic             wr_q, wr_d;
    logic [4:0]       code_q, code_d;

    logic wr_eff;
    logic misalign;

    // A fetch is never a store, whatever Wr_I says.
    assign wr_eff = Wr_I & ~Fetch_I;

    // Size 11 behaves like a word; bytes are always aligned.
    assign misalign = (Size_I[1] && (Addr_Low2_I != 2'b00))
                   || ((Size_I == 2'b01) && Addr_Low2_I[0]);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fetch_q <= 1'b0;
            wr_q    <= 1'b0;
            code_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fetch_q <= fetch_d;
            wr_q    <= wr_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fetch_d = fetch_q;
        wr_d    = wr_q;
        code_d  = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start_I) begin
                    fetch_d = Fetch_I;
                    wr_d    = wr_eff;
                    if (misalign) begin
                        code_d  = wr_eff ? 5'd5 : 5'd4;
                        state_d = S_FAULT;
                    end else begin
                        code_d  = 5'd0;
                        state_d = S_XLATE;
                    end
                end
            end
            S_XLATE: begin
                // Abort beats a translation result; an error beats an ack.
                if (Abort_I) begin
                    state_d = S_IDLE;
                end else if (TLB_Err_I) begin
                    if (wr_q && (TLB_Fault_I == 3'b001)) begin
                        code_d = 5'd1;
                    end else begin
                        code_d = wr_q ? 5'd3 : 5'd2;
                    end
                    state_d = S_FAULT;
                end else if (MMU_Ack_I) begin
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // Ready on the last allowed cycle still completes the access.
                if (Abort_I) begin
                    state_d = S_IDLE;
                end else if (Bus_Rdy_I) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    code_d  = fetch_q ? 5'd6 : 5'd7;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is decoded from registered state only.
    assign Pr_Req_O  = (state_q == S_XLATE);
    assign Bus_Req_O = (state_q == S_BUS);
    assign Bus_Wr_O  = (state_q == S_BUS) && wr_q;
    assign Done_O    = (state_q == S_DONE);
    assign IR_Load_O = (state_q == S_DONE) && fetch_q;
    assign Exc_O     = (state_q == S_FAULT);
    assign ExcCode_O = (state_q == S_FAULT) ? code_q : 5'd0;
    assign Busy_O    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: randomized scoreboard bench for mem_access_seq.
// Each access's outcome is predicted from a per-access response schedule.
module tb_mem_access_seq;

    localparam int TO = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start_I = 1'b0;
    logic       Fetch_I = 1'b0;
    logic       Wr_I = 1'b0;
    logic [1:0] Size_I = 2'b00;
    logic [1:0] Addr_Low2_I = 2'b00;
    logic       Abort_I = 1'b0;
    logic       Pr_Req_O;
    logic       MMU_Ack_I = 1'b0;
    logic       TLB_Err_I = 1'b0;
    logic [2:0] TLB_Fault_I = 3'b000;
    logic       Bus_Req_O;
    logic       Bus_Wr_O;
    logic       Bus_Rdy_I = 1'b0;
    logic       IR_Load_O;
    logic       Busy_O;
    logic       Done_O;
    logic       Exc_O;
    logic [4:0] ExcCode_O;

    mem_access_seq #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start_I(Start_I), .Fetch_I(Fetch_I),
        .Wr_I(Wr_I), .Size_I(Size_I), .Addr_Low2_I(Addr_Low2_I),
        .Abort_I(Abort_I), .Pr_Req_O(Pr_Req_O), .MMU_Ack_I(MMU_Ack_I),
        .TLB_Err_I(TLB_Err_I), .TLB_Fault_I(TLB_Fault_I),
        .Bus_Req_O(Bus_Req_O), .Bus_Wr_O(Bus_Wr_O), .Bus_Rdy_I(Bus_Rdy_I),
        .IR_Load_O(IR_Load_O), .Busy_O(Busy_O), .Done_O(Done_O),
        .Exc_O(Exc_O), .ExcCode_O(ExcCode_O)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // kind: 0 done, 1 exception, 2 aborted
    typedef struct {
        int kind;
        int code;
        int ir;
        int pr;
        int bus;
        int wr;
        int lat;
        int st;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor: counts request cycles and scores each finished access.
    initial begin
        int  pr_cnt = 0;
        int  bus_cnt = 0;
        bit  prev_busy = 1'b0;
        bit  prev_pulse = 1'b0;
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (mon_en) begin
                if (Pr_Req_O) pr_cnt++;
                if (Bus_Req_O) begin
                    bus_cnt++;
                    if (exp_q.size() == 0) chk("spurious_bus", 1, 0);
                    else chk("bus_wr", int'(Bus_Wr_O), exp_q[0].wr);
                end
                if (!Exc_O) chk("code_idle", int'(ExcCode_O), 0);
                if (!Done_O) chk("ir_idle", int'(IR_Load_O), 0);
                if (Done_O || Exc_O) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_pulse", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("kind", (Done_O && Exc_O) ? 3 : (Done_O ? 0 : 1),
                            e.kind);
                        chk("exc_code", int'(ExcCode_O),
                            (e.kind == 1) ? e.code : 0);
                        chk("ir_load", int'(IR_Load_O), e.ir);
                        chk("pr_cycles", pr_cnt, e.pr);
                        chk("bus_cycles", bus_cnt, e.bus);
                        chk("latency", cyc - e.st, e.lat);
                    end
                    pr_cnt = 0;
                    bus_cnt = 0;
                end else if (prev_busy && !Busy_O && !prev_pulse) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_idle", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("kind", 2, e.kind);
                        chk("pr_cycles", pr_cnt, e.pr);
                        chk("bus_cycles", bus_cnt, e.bus);
                        chk("abort_lat", cyc - 1 - e.st, e.lat);
                    end
                    pr_cnt = 0;
                    bus_cnt = 0;
                end
                prev_busy = Busy_O;
                prev_pulse = Done_O || Exc_O;
            end
        end
    end

    // m: XLATE cycle carrying the MMU answer; b: BUS cycle of Bus_Rdy_I
    // (b > TO means ready never comes); abk: cycle of Abort_I (0 = none).
    task automatic run_txn(input bit fetch, input bit wr,
                           input logic [1:0] size, input logic [1:0] low2,
                           input int m, input bit err, input bit both,
                           input logic [2:0] fault, input int b,
                           input int abk, input int gap);
        exp_t e;
        bit   we;
        bit   mis;
        int   win;
        we  = wr && !fetch;
        mis = (size[1] && low2 != 2'b00) || (size == 2'b01 && low2[0]);
        e.wr = int'(we);
        e.pr = 0;
        e.bus = 0;
        e.code = 0;
        e.ir = 0;
        if (mis) begin
            e.kind = 1;
            e.code = we ? 5 : 4;
            e.lat = 1;
        end else if (abk >= 1 && abk <= m) begin
            e.kind = 2;
            e.pr = abk;
            e.lat = abk;
        end else if (err) begin
            e.kind = 1;
            e.code = (fault == 3'b001 && we) ? 1 : (we ? 3 : 2);
            e.pr = m;
            e.lat = m + 1;
        end else begin
            e.pr = m;
            win = (b <= TO) ? b : TO;
            if (abk > m && abk <= m + win) begin
                e.kind = 2;
                e.bus = abk - m;
                e.lat = abk;
            end else if (b <= TO) begin
                e.kind = 0;
                e.bus = b;
                e.ir = int'(fetch);
                e.lat = m + b + 1;
            end else begin
                e.kind = 1;
                e.code = fetch ? 6 : 7;
                e.bus = TO;
                e.lat = m + TO + 1;
            end
        end
        @(negedge Clk);
        Start_I = 1'b1;
        Fetch_I = fetch;
        Wr_I = wr;
        Size_I = size;
        Addr_Low2_I = low2;
        Abort_I = 1'b0;
        MMU_Ack_I = 1'b0;
        TLB_Err_I = 1'b0;
        Bus_Rdy_I = 1'b0;
        TLB_Fault_I = fault;
        e.st = cyc;
        exp_q.push_back(e);
        for (int k = 1; k <= e.lat; k++) begin
            @(negedge Clk);
            Start_I = ($urandom % 4) == 0;
            Fetch_I = 1'($urandom);
            Wr_I = 1'($urandom);
            Size_I = 2'($urandom);
            Addr_Low2_I = 2'($urandom);
            MMU_Ack_I = !mis && k == m && (!err || both);
            TLB_Err_I = !mis && k == m && err;
            TLB_Fault_I = (k == m) ? fault : 3'($urandom);
            Bus_Rdy_I = !mis && ((k == m + b)
                        || (k <= m && ($urandom % 3) == 0));
            Abort_I = (k == abk);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge Clk);
            Start_I = 1'b0;
            Abort_I = 1'b0;
            MMU_Ack_I = 1'b0;
            TLB_Err_I = 1'b0;
            Bus_Rdy_I = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", int'(Busy_O), 0);
        chk("rst_pr", int'(Pr_Req_O), 0);
        chk("rst_bus", int'(Bus_Req_O), 0);
        chk("rst_pulses", int'({Done_O, Exc_O, IR_Load_O, Bus_Wr_O}), 0);
        chk("rst_code", int'(ExcCode_O), 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("rel_busy", int'(Busy_O), 0);
        chk("rel_outs", int'({Pr_Req_O, Bus_Req_O, Done_O, Exc_O}), 0);
        mon_en = 1'b1;

        run_txn(0, 0, 2'b10, 2'b00, 1, 0, 0, 3'd0, 1, 0, 1);
        run_txn(0, 1, 2'b01, 2'b01, 1, 0, 0, 3'd0, 1, 0, 0);
        run_txn(1, 0, 2'b10, 2'b10, 1, 0, 0, 3'd0, 1, 0, 0);
        run_txn(0, 1, 2'b10, 2'b00, 1, 1, 0, 3'd1, 1, 0, 0);
        run_txn(0, 0, 2'b10, 2'b00, 1, 1, 1, 3'd3, 1, 0, 1);
        run_txn(1, 0, 2'b10, 2'b00, 1, 0, 0, 3'd0, 5, 0, 0);
        run_txn(1, 0, 2'b10, 2'b00, 1, 0, 0, 3'd0, 4, 0, 0);
        run_txn(0, 1, 2'b10, 2'b00, 1, 0, 0, 3'd0, 5, 3, 0);
        run_txn(0, 0, 2'b10, 2'b00, 1, 0, 0, 3'd0, 1, 0, 0);
        run_txn(0, 1, 2'b00, 2'b11, 2, 0, 0, 3'd0, 2, 0, 1);
        run_txn(1, 1, 2'b11, 2'b01, 1, 0, 0, 3'd0, 1, 0, 0);
        run_txn(0, 1, 2'b10, 2'b00, 1, 0, 0, 3'd0, 5, 0, 0);
        run_txn(0, 0, 2'b01, 2'b11, 1, 0, 0, 3'd0, 1, 1, 2);

        for (int i = 0; i < 300; i++) begin
            int m;
            int b;
            int abk;
            m = 1 + int'($urandom % 3);
            b = 1 + int'($urandom % (TO + 1));
            abk = (($urandom % 4) == 0) ? 1 + int'($urandom % (m + b + 1)) : 0;
            run_txn(($urandom % 3) == 0, 1'($urandom), 2'($urandom),
                    (($urandom % 2) == 0) ? 2'b00 : 2'($urandom),
                    m, ($urandom % 5) == 0, 1'($urandom),
                    (($urandom % 2) == 0) ? 3'd1 : 3'($urandom),
                    b, abk, int'($urandom % 3));
        end

        @(negedge Clk);
        Start_I = 1'b0;
        Abort_I = 1'b0;
        MMU_Ack_I = 1'b0;
        TLB_Err_I = 1'b0;
        Bus_Rdy_I = 1'b0;
        repeat (4) @(negedge Clk);
        chk("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Asynchronous reset while waiting for translation.
        Start_I = 1'b1;
        Fetch_I = 1'b0;
        Wr_I = 1'b0;
        Size_I = 2'b10;
        Addr_Low2_I = 2'b00;
        @(posedge Clk);
        #1;
        Start_I = 1'b0;
        chk("xlate_pr", int'(Pr_Req_O), 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_pr", int'(Pr_Req_O), 0);
        chk("async_busy", int'(Busy_O), 0);
        @(negedge Clk);
        Reset = 1'b1;
        MMU_Ack_I = 1'b1;
        Bus_Rdy_I = 1'b1;
        repeat (3) begin
            @(posedge Clk);
            #1;
            chk("post_rst_idle", int'(Busy_O), 0);
        end
        MMU_Ack_I = 1'b0;
        Bus_Rdy_I = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
